// File: rtl/clusterv_mgmt_pkg.sv
// Shared types for the cluster management Wishbone path: FSM states, response
// status encoding and the default initiator timeout.
package clusterv_mgmt_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUS  = 2'd1;
   localparam state_t ST_RSP  = 2'd2;

   typedef logic [1:0] rsp_status_t;
   localparam rsp_status_t RSP_OK      = 2'd0;
   localparam rsp_status_t RSP_BUS_ERR = 2'd1;
   localparam rsp_status_t RSP_TIMEOUT = 2'd2;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

   // Terminal-cycle resolution: err beats ack, and either beats a timeout.
   function automatic rsp_status_t bus_status(input logic ack, input logic err, input logic tmo);
      if (err) return RSP_BUS_ERR;
      if (ack) return RSP_OK;
      if (tmo) return RSP_TIMEOUT;
      return RSP_OK;
   endfunction

endpackage

// File: rtl/clusterv_mgmt_wb_initiator.sv
// Management Wishbone initiator: one valid/ready command in, one classic cycle out,
// one response back. Optional bus timeout under CLUSTERV_MGMT_INIT_TIMEOUT_EN.
module clusterv_mgmt_wb_initiator
   import clusterv_mgmt_pkg::*;
#(
   parameter int unsigned ADR_WIDTH      = 32,
   parameter int unsigned DAT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                   mgmt_clock,
   input  logic                   mgmt_reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADR_WIDTH-1:0]   cmd_adr,
   input  logic [DAT_WIDTH-1:0]   cmd_dat,
   input  logic [DAT_WIDTH/8-1:0] cmd_sel,
   input  logic                   cmd_we,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DAT_WIDTH-1:0]   rsp_dat,
   output logic                   rsp_err,
   output logic                   rsp_timeout,
   output logic [ADR_WIDTH-1:0]   mgmt_adr,
   output logic [DAT_WIDTH-1:0]   mgmt_dat_w,
   input  logic [DAT_WIDTH-1:0]   mgmt_dat_r,
   output logic                   mgmt_cyc,
   output logic                   mgmt_stb,
   output logic [DAT_WIDTH/8-1:0] mgmt_sel,
   output logic                   mgmt_we,
   input  logic                   mgmt_ack,
   input  logic                   mgmt_err
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   state_t                   state, state_d;
   rsp_status_t              status_c;
   logic                     accept_c;
   logic                     tmo_hit_c;
   logic                     cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic                     cyc_d, stb_d, we_d;
   logic [DAT_WIDTH-1:0]     rsp_dat_d, dat_w_d;
   logic [ADR_WIDTH-1:0]     adr_d;
   logic [DAT_WIDTH/8-1:0]   sel_d;

   assign accept_c = (state == ST_IDLE) && cmd_valid && cmd_ready;

`ifdef CLUSTERV_MGMT_INIT_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] tmo_cnt;

   // Counts BUS cycles without a target response; cleared as the cycle starts.
   always_ff @(posedge mgmt_clock or posedge mgmt_reset) begin
      if (mgmt_reset)
         tmo_cnt <= '0;
      else if (accept_c)
         tmo_cnt <= '0;
      else if ((state == ST_BUS) && !mgmt_ack && !mgmt_err)
         tmo_cnt <= tmo_cnt + CNT_W'(1);
   end

   assign tmo_hit_c = (state == ST_BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit_c = 1'b0;
`endif

   assign status_c = bus_status(mgmt_ack, mgmt_err, tmo_hit_c);

   always_ff @(posedge mgmt_clock or posedge mgmt_reset) begin
      if (mgmt_reset) state <= ST_IDLE;
      else            state <= state_d;
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d       = state;
      rsp_valid_d   = rsp_valid;
      rsp_dat_d     = rsp_dat;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      cyc_d         = mgmt_cyc;
      stb_d         = mgmt_stb;
      adr_d         = mgmt_adr;
      dat_w_d       = mgmt_dat_w;
      sel_d         = mgmt_sel;
      we_d          = mgmt_we;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               adr_d   = cmd_adr;
               dat_w_d = cmd_dat;
               sel_d   = cmd_sel;
               we_d    = cmd_we;
            end
         end
         ST_BUS: begin
            if (mgmt_ack || mgmt_err || tmo_hit_c) begin
               state_d       = ST_RSP;
               cyc_d         = 1'b0;
               stb_d         = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = (status_c != RSP_OK);
               rsp_timeout_d = (status_c == RSP_TIMEOUT);
               rsp_dat_d     = ((status_c == RSP_OK) && !mgmt_we) ? mgmt_dat_r : '0;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge mgmt_clock or posedge mgmt_reset) begin
      if (mgmt_reset) begin
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_dat     <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         mgmt_cyc    <= 1'b0;
         mgmt_stb    <= 1'b0;
         mgmt_adr    <= '0;
         mgmt_dat_w  <= '0;
         mgmt_sel    <= '0;
         mgmt_we     <= 1'b0;
      end else begin
         cmd_ready   <= cmd_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_dat     <= rsp_dat_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
         mgmt_cyc    <= cyc_d;
         mgmt_stb    <= stb_d;
         mgmt_adr    <= adr_d;
         mgmt_dat_w  <= dat_w_d;
         mgmt_sel    <= sel_d;
         mgmt_we     <= we_d;
      end
   end

endmodule

// File: tb/tb_clusterv_mgmt_wb_initiator.sv
// Bench for clusterv_mgmt_wb_initiator: directed bring-up cases plus random traffic
// against a transaction-level expectation; honours CLUSTERV_MGMT_INIT_TIMEOUT_EN.
module tb_clusterv_mgmt_wb_initiator;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_dat;
   logic [31:0] mgmt_adr, mgmt_dat_w, mgmt_dat_r;
   logic        mgmt_cyc, mgmt_stb, mgmt_we, mgmt_ack, mgmt_err;
   logic [3:0]  mgmt_sel;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] cur_adr, cur_dat;
   logic [3:0]  cur_sel;
   logic        cur_we;

   clusterv_mgmt_wb_initiator #(
      .ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .mgmt_clock(clk), .mgmt_reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
      .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .mgmt_adr(mgmt_adr), .mgmt_dat_w(mgmt_dat_w), .mgmt_dat_r(mgmt_dat_r),
      .mgmt_cyc(mgmt_cyc), .mgmt_stb(mgmt_stb), .mgmt_sel(mgmt_sel),
      .mgmt_we(mgmt_we), .mgmt_ack(mgmt_ack), .mgmt_err(mgmt_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic scramble_cmd();
      cmd_adr = $urandom;
      cmd_dat = $urandom;
      cmd_sel = 4'($urandom);
      cmd_we  = 1'($urandom);
   endtask

   // Present a command, wait (bounded) for acceptance, then check the bus was loaded.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
      int n = 0;
      cur_adr = a; cur_dat = d; cur_sel = s; cur_we = w;
      cmd_valid = 1'b1; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_we = w;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      scramble_cmd();
      check("bus_cyc_stb", 32'({mgmt_cyc, mgmt_stb}), 32'd3);
      check("bus_adr", mgmt_adr, a);
      check("bus_dat_w", mgmt_dat_w, d);
      check("bus_sel", 32'(mgmt_sel), 32'(s));
      check("bus_we", 32'(mgmt_we), 32'(w));
      check("busy_ready", 32'(cmd_ready), 32'd0);
   endtask

   // kind: 0 = ack, 1 = err, 2 = ack+err. Target responds after 'waits' wait states.
   task automatic complete(input int waits, input int kind, input logic [31:0] rdata, input int hold);
      logic        exp_err;
      logic [31:0] exp_dat;
      exp_err = (kind != 0);
      exp_dat = (exp_err || cur_we) ? 32'd0 : rdata;
      for (int c = 0; c < waits; c++) begin
         mgmt_dat_r = $urandom;
         @(posedge clk); #1;
         check("wait_cyc", 32'({mgmt_cyc, mgmt_stb}), 32'd3);
         check("wait_adr", mgmt_adr, cur_adr);
         check("wait_rsp", 32'(rsp_valid), 32'd0);
      end
      mgmt_ack   = (kind != 1);
      mgmt_err   = (kind != 0);
      mgmt_dat_r = rdata;
      @(posedge clk); #1;
      mgmt_ack = 1'b0; mgmt_err = 1'b0; mgmt_dat_r = $urandom;
      check("end_cyc_stb", 32'({mgmt_cyc, mgmt_stb}), 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_dat", rsp_dat, exp_dat);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_timeout", 32'(rsp_timeout), 32'd0);
      // Back-pressure: response held, new command and stray acks ignored.
      for (int c = 0; c < hold; c++) begin
         cmd_valid = 1'b1;
         scramble_cmd();
         mgmt_ack = 1'($urandom);
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_dat", rsp_dat, exp_dat);
         check("hold_err", 32'(rsp_err), 32'(exp_err));
         check("hold_ready", 32'(cmd_ready), 32'd0);
         check("hold_cyc", 32'(mgmt_cyc), 32'd0);
      end
      mgmt_ack  = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_cyc", 32'(mgmt_cyc), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      mgmt_ack = 1'b0; mgmt_err = 1'b0; mgmt_dat_r = '0;
      cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'd0);
      check("rst_bus_ctl", 32'({mgmt_cyc, mgmt_stb, mgmt_we}), 32'd0);
      check("rst_bus_adr", mgmt_adr, 32'd0);
      check("rst_bus_dat", mgmt_dat_w, 32'd0);
      check("rst_bus_sel", 32'(mgmt_sel), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed: zero-wait write, 5-wait read, ack+err, long back-pressure.
      issue(32'h1000_0000, 32'h2000_0000, 4'hF, 1'b1);
      complete(0, 0, 32'h0BAD_0BAD, 0);
      issue(32'h1000_0000, 32'h5555_AAAA, 4'hF, 1'b0);
      complete(5, 0, 32'hDEAD_BEEF, 0);
      issue(32'h1000_0004, 32'h0, 4'h3, 1'b0);
      complete(2, 2, 32'h1234_5678, 0);
      issue(32'h1000_0008, 32'hCAFE_F00D, 4'h1, 1'b1);
      complete(1, 0, 32'h0, 10);

      // Random traffic.
      for (int t = 0; t < 40; t++) begin
         int k;
         k = int'($urandom_range(9, 0));
         issue($urandom, $urandom, 4'($urandom), 1'($urandom));
         complete(int'($urandom_range(6, 0)), (k < 6) ? 0 : ((k < 8) ? 1 : 2),
                  $urandom, int'($urandom_range(3, 0)));
      end

      // Unresponsive target.
      issue(32'h2000_0000, 32'h0, 4'hF, 1'b0);
`ifdef CLUSTERV_MGMT_INIT_TIMEOUT_EN
      n = 0;
      while (mgmt_cyc === 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("tmo_cyc_cycles", 32'(n), 32'(TMO));
      check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
      check("tmo_rsp_err", 32'(rsp_err), 32'd1);
      check("tmo_rsp_timeout", 32'(rsp_timeout), 32'd1);
      check("tmo_rsp_dat", rsp_dat, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("tmo_post_ready", 32'(cmd_ready), 32'd1);
      issue(32'h2000_0010, 32'h0, 4'hF, 1'b0);
      repeat (3) @(posedge clk);
`else
      n = 0;
      repeat (1000) @(posedge clk);
      #1;
      check("notmo_cyc_held", 32'({mgmt_cyc, mgmt_stb}), 32'd3);
      check("notmo_no_rsp", 32'(rsp_valid), 32'd0);
`endif

      // Asynchronous reset while a bus cycle is open.
      #3 rst = 1'b1;
      #1;
      check("arst_cyc_stb", 32'({mgmt_cyc, mgmt_stb}), 32'd0);
      check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_idle_cyc", 32'(mgmt_cyc), 32'd0);
      check("arst_idle_rsp", 32'(rsp_valid), 32'd0);
      issue(32'h1000_0000, 32'h0, 4'hF, 1'b0);
      complete(3, 0, 32'hA5A5_5A5A, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
